// File: rtl/huff_pkg.sv
// Shared constants and state type for the canonical Huffman decoder.
package huff_pkg;

    localparam int HUFF_MAX_LEN = 8;
    localparam int HUFF_MAX_SYM = 20;
    localparam int LEN_W        = 4;

    typedef enum logic [1:0] {
        LOAD,
        BUILD,
        DECODE,
        ERR
    } huff_state_e;

endpackage

// File: rtl/huff_dec_table.sv
// Per-length canonical tables: code counts, first codes and first symbol indices.
// With HUFF_DEC_KRAFT_CHECK_EN defined, build_ok also requires a complete code.
module huff_dec_table
    import huff_pkg::*;
#(
    parameter int MAX_LEN = HUFF_MAX_LEN,
    parameter int MAX_SYM = HUFF_MAX_SYM
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             inc_en,
    input  logic [LEN_W-1:0]                 inc_len,
    input  logic                             build_en,
    output logic                             build_last,
    output logic                             build_ok,
    input  logic [LEN_W-1:0]                 look_len,
    output logic [MAX_LEN:0]                 look_first_code,
    output logic [$clog2(MAX_SYM+1)-1:0]     look_first_idx,
    output logic [$clog2(MAX_SYM+1)-1:0]     look_cnt
);

    localparam int CW = $clog2(MAX_SYM + 1);
    localparam int FW = MAX_LEN + 1;

    logic [CW-1:0]    cnt        [0:MAX_LEN];
    logic [FW-1:0]    first_code [0:MAX_LEN];
    logic [CW-1:0]    first_idx  [0:MAX_LEN];
    logic [LEN_W-1:0] bld_l;
    logic [LEN_W-1:0] prev_l;
    logic [FW-1:0]    build_fc;

    assign prev_l     = bld_l - 1'b1;
    assign build_last = (bld_l == LEN_W'(MAX_LEN));
    assign build_fc   = FW'((32'(first_code[prev_l]) + 32'(cnt[prev_l])) << 1);

`ifdef HUFF_DEC_KRAFT_CHECK_EN
    assign build_ok = ((32'(build_fc) + 32'(cnt[MAX_LEN])) == (32'd1 << MAX_LEN));
`else
    assign build_ok = 1'b1;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i <= MAX_LEN; i++) begin
                cnt[i] <= '0;
            end
        end else if (inc_en) begin
            cnt[inc_len] <= cnt[inc_len] + 1'b1;
        end
    end

    // One length per build cycle; each entry depends only on the previous length.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bld_l <= LEN_W'(1);
            for (int i = 0; i <= MAX_LEN; i++) begin
                first_code[i] <= '0;
                first_idx[i]  <= '0;
            end
        end else if (build_en) begin
            first_code[bld_l] <= build_fc;
            first_idx[bld_l]  <= first_idx[prev_l] + cnt[prev_l];
            if (!build_last) begin
                bld_l <= bld_l + 1'b1;
            end
        end
    end

    assign look_first_code = first_code[look_len];
    assign look_first_idx  = first_idx[look_len];
    assign look_cnt        = cnt[look_len];

endmodule

// File: rtl/huffman_decoder.sv
// Canonical Huffman decoder: table load, per-length build, then bit-serial decode.
// Optional completeness check at end of build: define HUFF_DEC_KRAFT_CHECK_EN.
module huffman_decoder
    import huff_pkg::*;
#(
    parameter int MAX_LEN = HUFF_MAX_LEN,
    parameter int MAX_SYM = HUFF_MAX_SYM
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tbl_enb,
    input  logic [7:0]       tbl_syml,
    input  logic [LEN_W-1:0] tbl_len,
    input  logic             tbl_done,
    input  logic             bit_valid,
    input  logic             bit_in,
    output logic             bit_ready,
    output logic [7:0]       dec_syml,
    output logic             dec_valid,
    output logic             err
);

    localparam int CW = $clog2(MAX_SYM + 1);
    localparam int FW = MAX_LEN + 1;

    huff_state_e state;
    huff_state_e state_nxt;

    logic [CW-1:0]      idx;
    logic [7:0]         sym_mem [0:MAX_SYM-1];
    logic [MAX_LEN-1:0] code;
    logic [LEN_W-1:0]   len;

    logic               entry_bad;
    logic               load_store;
    logic               build_en;
    logic               accept;
    logic               build_last;
    logic               build_ok;
    logic [LEN_W-1:0]   cur_l;
    logic [FW-1:0]      c;
    logic [FW-1:0]      diff;
    logic               hit;
    logic [CW-1:0]      sym_addr;
    logic [FW-1:0]      look_first_code;
    logic [CW-1:0]      look_first_idx;
    logic [CW-1:0]      look_cnt;

    huff_dec_table #(
        .MAX_LEN (MAX_LEN),
        .MAX_SYM (MAX_SYM)
    ) u_table (
        .clk             (clk),
        .reset           (reset),
        .inc_en          (load_store),
        .inc_len         (tbl_len),
        .build_en        (build_en),
        .build_last      (build_last),
        .build_ok        (build_ok),
        .look_len        (cur_l),
        .look_first_code (look_first_code),
        .look_first_idx  (look_first_idx),
        .look_cnt        (look_cnt)
    );

    assign entry_bad = (idx == CW'(MAX_SYM)) || (tbl_len == '0) || (tbl_len > LEN_W'(MAX_LEN));

    // Candidate code including the incoming bit, matched against its length's range.
    assign cur_l    = len + 1'b1;
    assign c        = {code, bit_in};
    assign diff     = c - look_first_code;
    assign hit      = (c >= look_first_code) && (32'(diff) < 32'(look_cnt));
    assign sym_addr = CW'(32'(look_first_idx) + 32'(diff));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        load_store = 1'b0;
        build_en   = 1'b0;
        accept     = 1'b0;
        case (state)
            LOAD: begin
                if (tbl_enb && entry_bad) begin
                    state_nxt = ERR;
                end else begin
                    load_store = tbl_enb;
                    if (tbl_done) begin
                        state_nxt = (tbl_enb || idx != '0) ? BUILD : ERR;
                    end
                end
            end
            BUILD: begin
                build_en = 1'b1;
                if (build_last) begin
                    state_nxt = build_ok ? DECODE : ERR;
                end
            end
            DECODE: begin
                accept = bit_valid;
                if (bit_valid && !hit && cur_l == LEN_W'(MAX_LEN)) begin
                    state_nxt = ERR;
                end
            end
            default: begin
                state_nxt = ERR;
            end
        endcase
    end

    assign bit_ready = (state == DECODE);
    assign err       = (state == ERR);

    always_ff @(posedge clk) begin
        if (load_store) begin
            sym_mem[idx] <= tbl_syml;
        end
    end

    // Bit accumulator and registered symbol output; a match restarts the code.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx       <= '0;
            code      <= '0;
            len       <= '0;
            dec_valid <= 1'b0;
            dec_syml  <= 8'h00;
        end else begin
            dec_valid <= 1'b0;
            if (load_store) begin
                idx <= idx + 1'b1;
            end
            if (accept) begin
                if (hit) begin
                    dec_valid <= 1'b1;
                    dec_syml  <= sym_mem[sym_addr];
                    code      <= '0;
                    len       <= '0;
                end else begin
                    code <= c[MAX_LEN-1:0];
                    len  <= cur_l;
                end
            end
        end
    end

endmodule

// File: tb/tb_huffman_decoder.sv
// Self-checking bench for huffman_decoder: directed cases plus random tables/streams
// compared every cycle against a dictionary-lookup model.
module tb_huffman_decoder;

    localparam int ML = huff_pkg::HUFF_MAX_LEN;
    localparam int MS = huff_pkg::HUFF_MAX_SYM;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tbl_enb = 1'b0;
    logic [7:0] tbl_syml = 8'h00;
    logic [3:0] tbl_len = 4'h0;
    logic       tbl_done = 1'b0;
    logic       bit_valid = 1'b0;
    logic       bit_in = 1'b0;
    logic       bit_ready;
    logic [7:0] dec_syml;
    logic       dec_valid;
    logic       err;

    int checks = 0;
    int passes = 0;
    bit cmp_en = 1'b0;

    int tbl_s[$];
    int tbl_l[$];

    always #5 clk = ~clk;

    huffman_decoder dut (
        .clk       (clk),
        .reset     (reset),
        .tbl_enb   (tbl_enb),
        .tbl_syml  (tbl_syml),
        .tbl_len   (tbl_len),
        .tbl_done  (tbl_done),
        .bit_valid (bit_valid),
        .bit_in    (bit_in),
        .bit_ready (bit_ready),
        .dec_syml  (dec_syml),
        .dec_valid (dec_valid),
        .err       (err)
    );

    // Reference model: entries with explicitly assigned canonical codes, decoded by lookup.
    typedef enum {M_LOAD, M_BUILD, M_DECODE, M_ERR} mphase_e;
    mphase_e    m_phase;
    int         m_sym[$];
    int         m_len[$];
    int         m_code[$];
    int         m_build_left;
    int         m_acc;
    int         m_alen;
    logic       m_valid;
    logic [7:0] m_syml;

    task automatic modelClear();
        m_phase = M_LOAD;
        m_sym.delete();
        m_len.delete();
        m_code.delete();
        m_build_left = 0;
        m_acc = 0;
        m_alen = 0;
        m_valid = 1'b0;
        m_syml = 8'h00;
    endtask

    function automatic bit modelAssignCodes();
        int code = 0;
        int prev = m_len[0];
        longint kraft = 0;
        m_code.delete();
        for (int i = 0; i < m_len.size(); i++) begin
            code = code << (m_len[i] - prev);
            prev = m_len[i];
            m_code.push_back(code);
            code++;
            kraft += longint'(1) << (ML - m_len[i]);
        end
`ifdef HUFF_DEC_KRAFT_CHECK_EN
        return kraft == (longint'(1) << ML);
`else
        return 1'b1;
`endif
    endfunction

    task automatic modelStep();
        bit found;
        m_valid = 1'b0;
        case (m_phase)
            M_LOAD: begin
                if (tbl_enb && (m_sym.size() == MS || tbl_len == 0 || int'(tbl_len) > ML)) begin
                    m_phase = M_ERR;
                end else begin
                    if (tbl_enb) begin
                        m_sym.push_back(int'(tbl_syml));
                        m_len.push_back(int'(tbl_len));
                    end
                    if (tbl_done) begin
                        m_phase = (m_sym.size() == 0) ? M_ERR : M_BUILD;
                        m_build_left = ML;
                    end
                end
            end
            M_BUILD: begin
                m_build_left--;
                if (m_build_left == 0) begin
                    m_phase = modelAssignCodes() ? M_DECODE : M_ERR;
                end
            end
            M_DECODE: begin
                if (bit_valid) begin
                    m_acc = m_acc * 2 + int'(bit_in);
                    m_alen++;
                    found = 1'b0;
                    for (int i = 0; i < m_sym.size(); i++) begin
                        if (!found && m_len[i] == m_alen && m_code[i] == m_acc) begin
                            found = 1'b1;
                            m_valid = 1'b1;
                            m_syml = 8'(m_sym[i]);
                        end
                    end
                    if (found) begin
                        m_acc = 0;
                        m_alen = 0;
                    end else if (m_alen == ML) begin
                        m_phase = M_ERR;
                    end
                end
            end
            default: ;
        endcase
    endtask

    initial begin
        modelClear();
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) modelClear();
            else modelStep();
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Per-cycle comparison of every output against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                checkOutput("model.bit_ready", 32'(bit_ready), 32'(m_phase == M_DECODE));
                checkOutput("model.err", 32'(err), 32'(m_phase == M_ERR));
                checkOutput("model.dec_valid", 32'(dec_valid), 32'(m_valid));
                checkOutput("model.dec_syml", 32'(dec_syml), 32'(m_syml));
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic enb, input logic [7:0] s, input logic [3:0] l,
                                 input logic done, input logic bv, input logic b);
        tbl_enb   = enb;
        tbl_syml  = s;
        tbl_len   = l;
        tbl_done  = done;
        bit_valid = bv;
        bit_in    = b;
        tick();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 8'h00, 4'h0, 0, 0, 0);
    endtask

    task automatic sendBit(input logic b);
        applyStimulus(0, 8'h00, 4'h0, 0, 1, b);
    endtask

    task automatic doReset();
        reset = 1'b0;
        idle(2);
        reset = 1'b1;
        idle(1);
    endtask

    task automatic loadTable();
        for (int i = 0; i < tbl_s.size(); i++) begin
            applyStimulus(1, 8'(tbl_s[i]), 4'(tbl_l[i]), 0, 0, 0);
        end
        applyStimulus(0, 8'h00, 4'h0, 1, 0, 0);
    endtask

    task automatic setTableA();
        tbl_s = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45};
        tbl_l = '{2, 2, 2, 3, 3};
    endtask

    task automatic randomTable();
        int lens[$];
        int n;
        int cand[$];
        int pick;
        int depth;
        int s;
        lens.push_back(0);
        n = $urandom_range(2, MS);
        while (lens.size() < n) begin
            cand.delete();
            for (int i = 0; i < lens.size(); i++) if (lens[i] < ML) cand.push_back(i);
            pick = cand[$urandom_range(0, cand.size() - 1)];
            depth = lens[pick] + 1;
            lens.delete(pick);
            lens.push_back(depth);
            lens.push_back(depth);
        end
        lens.sort();
        if ($urandom_range(0, 2) == 0) void'(lens.pop_back());
        tbl_s.delete();
        tbl_l.delete();
        s = $urandom_range(0, 200);
        for (int i = 0; i < lens.size(); i++) begin
            s += $urandom_range(1, 2);
            tbl_s.push_back(s);
            tbl_l.push_back(lens[i]);
        end
    endtask

    initial begin
        #1 reset = 1'b0;
        cmp_en = 1'b1;
        idle(2);
        checkOutput("reset.bit_ready", 32'(bit_ready), 32'd0);
        checkOutput("reset.dec_valid", 32'(dec_valid), 32'd0);
        checkOutput("reset.dec_syml", 32'(dec_syml), 32'h00);
        checkOutput("reset.err", 32'(err), 32'd0);
        reset = 1'b1;
        idle(1);

        // Table A: codes 00,01,10 for 0x41..0x43 and 110,111 for 0x44,0x45.
        setTableA();
        loadTable();
        idle(ML - 1);
        checkOutput("build.ready_low", 32'(bit_ready), 32'd0);
        idle(1);
        checkOutput("build.ready_high", 32'(bit_ready), 32'd1);
        sendBit(0);
        checkOutput("a.first_bit_valid", 32'(dec_valid), 32'd0);
        sendBit(0);
        checkOutput("a.sym41_valid", 32'(dec_valid), 32'd1);
        checkOutput("a.sym41", 32'(dec_syml), 32'h41);
        sendBit(1);
        sendBit(1);
        checkOutput("a.partial_valid", 32'(dec_valid), 32'd0);
        sendBit(0);
        checkOutput("a.sym44_valid", 32'(dec_valid), 32'd1);
        checkOutput("a.sym44", 32'(dec_syml), 32'h44);
        sendBit(1);
        checkOutput("a.b2b_ready1", 32'(bit_ready), 32'd1);
        sendBit(1);
        checkOutput("a.b2b_ready2", 32'(bit_ready), 32'd1);
        checkOutput("a.b2b_novalid", 32'(dec_valid), 32'd0);
        sendBit(1);
        checkOutput("a.sym45_valid", 32'(dec_valid), 32'd1);
        checkOutput("a.sym45", 32'(dec_syml), 32'h45);
        idle(1);
        checkOutput("a.valid_pulse", 32'(dec_valid), 32'd0);
        checkOutput("a.syml_hold", 32'(dec_syml), 32'h45);

        // Single one-bit entry.
        doReset();
        tbl_s = '{8'h10};
        tbl_l = '{1};
        loadTable();
        idle(ML);
`ifdef HUFF_DEC_KRAFT_CHECK_EN
        checkOutput("single.kraft_err", 32'(err), 32'd1);
        checkOutput("single.kraft_ready", 32'(bit_ready), 32'd0);
`else
        sendBit(0);
        checkOutput("single.sym10", 32'(dec_syml), 32'h10);
        checkOutput("single.valid", 32'(dec_valid), 32'd1);
        for (int i = 0; i < ML - 1; i++) sendBit(1);
        checkOutput("single.err_before_max", 32'(err), 32'd0);
        sendBit(1);
        checkOutput("single.err_at_max", 32'(err), 32'd1);
        checkOutput("single.ready_in_err", 32'(bit_ready), 32'd0);
        sendBit(0);
        checkOutput("single.no_valid_in_err", 32'(dec_valid), 32'd0);
`endif

        // Empty table.
        doReset();
        applyStimulus(0, 8'h00, 4'h0, 1, 0, 0);
        checkOutput("empty.err", 32'(err), 32'd1);
        idle(ML + 2);
        checkOutput("empty.ready", 32'(bit_ready), 32'd0);
        checkOutput("empty.err_sticky", 32'(err), 32'd1);

        // Symbol storage overflow on entry MS+1.
        doReset();
        for (int i = 0; i < MS; i++) applyStimulus(1, 8'(i), 4'(ML), 0, 0, 0);
        checkOutput("ovf.no_err_at_max", 32'(err), 32'd0);
        applyStimulus(1, 8'hEE, 4'(ML), 0, 0, 0);
        checkOutput("ovf.err", 32'(err), 32'd1);

        // Reset in the middle of a code, then reload.
        doReset();
        setTableA();
        loadTable();
        idle(ML);
        sendBit(0);
        sendBit(0);
        sendBit(1);
        sendBit(1);
        reset = 1'b0;
        idle(1);
        checkOutput("midrst.ready", 32'(bit_ready), 32'd0);
        checkOutput("midrst.valid", 32'(dec_valid), 32'd0);
        checkOutput("midrst.syml", 32'(dec_syml), 32'h00);
        checkOutput("midrst.err", 32'(err), 32'd0);
        reset = 1'b1;
        idle(1);
        loadTable();
        idle(ML);
        sendBit(0);
        sendBit(1);
        checkOutput("midrst.sym42_valid", 32'(dec_valid), 32'd1);
        checkOutput("midrst.sym42", 32'(dec_syml), 32'h42);

        // Length beyond MAX_LEN.
        doReset();
        applyStimulus(1, 8'h41, 4'd2, 0, 0, 0);
        checkOutput("badlen.no_err", 32'(err), 32'd0);
        applyStimulus(1, 8'h50, 4'(ML + 1), 0, 0, 0);
        checkOutput("badlen.err", 32'(err), 32'd1);

        // Random tables and streams, checked each cycle by the model.
        for (int r = 0; r < 10; r++) begin
            doReset();
            randomTable();
            for (int i = 0; i < tbl_s.size(); i++) begin
                if ($urandom_range(0, 3) == 0) idle(1);
                applyStimulus(1, 8'(tbl_s[i]), 4'(tbl_l[i]),
                              (i == tbl_s.size() - 1) && ($urandom_range(0, 1) == 1), 0, 0);
            end
            if (m_phase == M_LOAD) applyStimulus(0, 8'h00, 4'h0, 1, 0, 0);
            for (int k = 0; k < ML + 150; k++) begin
                applyStimulus($urandom_range(0, 15) == 0, 8'($urandom), 4'($urandom),
                              $urandom_range(0, 15) == 0, $urandom_range(0, 4) != 0,
                              1'($urandom));
            end
        end

        idle(2);
        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/huffman_decoder.md
# huffman_decoder

Canonical Huffman decoder, the receive-side counterpart of the canonical Huffman encoder chain. It loads a canonical code-length table (symbol, length) one entry per cycle and builds per-length first-code/first-index tables. It then decodes a serial bitstream, one bit per cycle, into 8-bit symbols. It sits after the bit-stream deserializer and feeds decoded symbols to the downstream consumer.

## Interface
- MAX_LEN, 8, longest supported code length in bits (1..15)
- MAX_SYM, 20, symbol storage depth
- clk  in  1  clock; all logic on rising edge
- reset  in  1  asynchronous, active-low
- tbl_enb  in  1  table entry valid
- tbl_syml  in  8  table symbol
- tbl_len  in  4  code length, 1..MAX_LEN; entries arrive sorted by ascending length, then ascending symbol
- tbl_done  in  1  single-cycle pulse marking end of table
- bit_valid  in  1  serial bit valid
- bit_in  in  1  serial bit, MSB of each code first
- bit_ready  out  1  decoder accepts a bit this cycle
- dec_syml  out  8  decoded symbol
- dec_valid  out  1  one-cycle pulse, dec_syml valid
- err  out  1  sticky error flag

## Operation
- States: LOAD (after reset) -> BUILD -> DECODE; any state -> ERR; ERR exits only on reset.
- LOAD: on tbl_enb, sym_mem[idx] <= tbl_syml; idx++; cnt[tbl_len]++. tbl_enb with idx == MAX_SYM, or tbl_len of 0 or > MAX_LEN -> ERR. tbl_done -> BUILD. tbl_done with idx == 0 -> ERR. tbl_enb and tbl_done in the same cycle: store the entry, then go to BUILD.
- BUILD: one length per cycle, l = 1..MAX_LEN: first_code[l] = (first_code[l-1] + cnt[l-1]) << 1; first_idx[l] = first_idx[l-1] + cnt[l-1]; base values are 0. After l = MAX_LEN -> DECODE.
- DECODE: bit_ready = 1. On bit_valid && bit_ready: c = {code, bit_in}, l = len + 1.
  - Match when c >= first_code[l] and c - first_code[l] < cnt[l]: emit sym_mem[first_idx[l] + c - first_code[l]], then clear code and len.
  - No match and l == MAX_LEN -> ERR.
  - Otherwise code <= c; len <= l.
- tbl_enb and tbl_done are ignored outside LOAD. bit_valid is ignored outside DECODE.
- Widths: code is MAX_LEN bits; first_code is MAX_LEN+1 bits to hold the overflow; cnt and first_idx are clog2(MAX_SYM+1) bits. All comparisons are unsigned.
- ERR: bit_ready = 0, err = 1; dec_valid is never asserted.

## Timing
- Reset values: bit_ready 0, dec_valid 0, dec_syml 8'h00, err 0; state LOAD; idx, cnt, code and len all 0.
- BUILD takes exactly MAX_LEN cycles. bit_ready rises on the cycle after the last BUILD cycle.
- Throughput is one bit per cycle, back-to-back.
- dec_valid and dec_syml are registered and appear the cycle after the edge that accepted the final bit of a code.
- dec_syml holds its value until the next match.
- err asserts the cycle after the offending edge and stays asserted.
- Asynchronous reset mid-table or mid-code returns the block to LOAD and discards all tables and any partial code.

## Configuration
- HUFF_DEC_KRAFT_CHECK_EN defined: on the final BUILD cycle, the block checks first_code[MAX_LEN] + cnt[MAX_LEN] == 2^MAX_LEN. Over- or under-subscribed tables go to ERR instead of DECODE.
- Undefined: the completeness check is omitted. Incomplete tables are accepted, and unmatched codes flag err only when they reach MAX_LEN bits.

## Structure
- Package huff_pkg holds: MAX_LEN and MAX_SYM defaults, the state enum {LOAD, BUILD, DECODE, ERR}, and the length-field width constant (4).
- Sub-module huff_dec_table owns cnt, first_code, first_idx and the BUILD iteration. It exposes the per-length lookup to the decode datapath.
- Top level owns sym_mem, the FSM and the bit accumulator.

## Test plan
- Table 0x41/2, 0x42/2, 0x43/2, 0x44/3, 0x45/3; bits 0,0,1,1,0 -> dec_syml 0x41 then 0x44; each dec_valid arrives the cycle after the last bit of its code.
- Same table; bits 1,1,1 back-to-back -> single dec_valid with 0x45; bit_ready held high throughout.
- Single entry 0x10/1; bit 0 -> 0x10. Bit 1 with MAX_LEN=1 -> err=1, bit_ready=0. With HUFF_DEC_KRAFT_CHECK_EN defined -> err set at end of BUILD.
- tbl_done with no entries -> err=1 and bit_ready never rises. 21 entries with MAX_SYM=20 -> err on the 21st.
- Reset asserted after bits 1,1 of a 3-bit code -> all outputs return to 0; reload table and decode 0,1 -> 0x42.
- Table with tbl_len 9 when MAX_LEN=8 -> err=1 the cycle after that entry.
